muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the execute stage. Sits beside the ALU and consumes the
//  same register-file operands (rs -> a, rt -> b). Owns the architectural HI/LO registers.
//  Results go to the writeback result mux via MFHI/MFLO. The controller stalls PC fetch while busy.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clk     in   1      clock
//  reset   in   1      synchronous, active-high
//  start   in   1      launch operation op on a,b (sampled at posedge)
//  op      in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a       in   WIDTH  multiplicand / dividend (rs)
//  b       in   WIDTH  multiplier / divisor (rt)
//  hi_we   in   1      MTHI: hi <= wdata
//  lo_we   in   1      MTLO: lo <= wdata
//  wdata   in   WIDTH  MTHI/MTLO data (rs)
//  busy    out  1      operation in flight; controller stalls while high
//  done    out  1      one-cycle pulse; new hi/lo visible in this cycle
//  hi      out  WIDTH  HI register (mult: upper product; div: remainder)
//  lo      out  WIDTH  LO register (mult: lower product; div: quotient)
// BEHAVIOUR
//  Reset: state=IDLE; hi=0; lo=0; busy=0; done=0. Reset mid-operation aborts the operation,
//   clears hi/lo, and produces no done pulse.
//  FSM: IDLE -start-> CALC (WIDTH cycles, counter WIDTH-1..0) -> FIX (1 cycle) -> IDLE.
//  busy = (state != IDLE), registered. done is high in the first IDLE cycle after FIX.
//  Latency: start sampled at edge 0; hi/lo updated at edge WIDTH+1; done=1 during cycle WIDTH+2.
//   For WIDTH=32, start -> done is 34 cycles.
//  start while busy: ignored. start in the cycle done=1: accepted (state is IDLE).
//  Launch (IDLE & start): latch op. Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
//   Record neg_q = a[W-1]^b[W-1] and neg_r = a[W-1], signed ops only.
//  CALC mult: radix-2 shift-add over a 2*WIDTH accumulator; one multiplier bit per cycle.
//  CALC div: restoring division; one quotient bit per cycle; partial remainder WIDTH+1 bits.
//  FIX:
//   MULT: negate 2*WIDTH product if neg_q. {hi,lo} <= product.
//   DIV:  lo <= neg_q ? -q : q; hi <= neg_r ? -r : r.
//   Quotient rounds toward zero; remainder takes the dividend's sign.
//   Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
//   Divide by zero (b==0, DIVU or DIV): lo=all ones, hi=raw a, no sign fixup. Full latency still applies.
//  hi_we/lo_we: take effect at the next edge only when IDLE and not start.
//   Ignored while busy, and ignored in a cycle where start is accepted (start wins).
//  hi/lo hold their old values throughout CALC. The controller stalls MFHI/MFLO while busy.
//  No arithmetic exceptions; all adds/subtracts wrap modulo 2^WIDTH.
// STRUCTURE
//  Package muldiv_pkg holds:
//   - op encodings (OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11)
//   - FSM state encoding (S_IDLE, S_CALC, S_FIX)
//   - the WIDTH default
//  Sub-module muldiv_step: combinational single iteration; one shift-add or one restore step,
//   selected by op[1]. muldiv_unit instantiates it once and holds the counter, operand and
//   accumulator registers, sign flags and FSM.
// TESTING
//  1 reset; MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy next cycle; done at cycle 34; hi=0xFFFFFFFE lo=0x00000001
//  2 MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIVU a=100 b=7 -> lo=14 hi=2
//  3 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0
//  4 DIVU a=5 b=0 -> done at cycle 34; lo=0xFFFFFFFF hi=5
//  5 MULTU 3*4; start(DIVU 9/2) and hi_we(wdata=0xAA) at cycle 5 -> both ignored; result hi=0 lo=12
//    then reset at cycle 10 of a new MULTU -> busy=0, hi=lo=0 next cycle, no done pulse
//  6 start (DIVU 9/2) in the done cycle of a MULTU 3*4 -> accepted; 34 cycles later lo=4 hi=1
//    MTLO 0x55 while idle -> lo=0x55 after one edge

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states, default width.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   function automatic logic op_is_div(input logic [1:0] o);
      case (o)
         OP_MULTU, OP_MULT: return 1'b0;
         OP_DIVU, OP_DIV:   return 1'b1;
         default:           return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_signed(input logic [1:0] o);
      case (o)
         OP_MULT, OP_DIV:   return 1'b1;
         OP_MULTU, OP_DIVU: return 1'b0;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: a radix-2 shift-add step or a restoring-division step.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_n
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // acc = {upper, lower}: mult keeps {partial product, multiplier}; div keeps {remainder, dividend/quotient}
   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - opnd;
      acc_n   = {sum, acc[WIDTH-1:1]};
      if (is_div) begin
         if (shifted >= {1'b0, opnd})
            acc_n = {diff, acc[WIDTH-2:0], 1'b1};
         else
            acc_n = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one result bit per cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t                  state, state_n;
   logic [CW-1:0]           cnt;
   logic                    div_r, neg_q, neg_r, divz;
   logic [2*WIDTH-1:0]      acc, acc_n;
   logic [WIDTH-1:0]        opnd;
   logic                    launch, sgn_op, div_op;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH-1:0]        a_abs, b_abs;
   logic [2*WIDTH-1:0]      prod_fix;
   logic [WIDTH-1:0]        q_fix, r_fix;

   always_comb begin
      sgn_op = op_is_signed(op);
      div_op = op_is_div(op);
      a_s    = signed'(a);
      b_s    = signed'(b);
      a_abs  = (sgn_op && a_s < 0) ? -a_s : a_s;
      b_abs  = (sgn_op && b_s < 0) ? -b_s : b_s;
      launch = (state == S_IDLE) && start;
   end

   // Sign fixup; a zero divisor leaves |a| as remainder, so only the quotient needs overriding
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      q_fix    = divz ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   assign busy = (state != S_IDLE);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (div_r),
      .acc    (acc),
      .opnd   (opnd),
      .acc_n  (acc_n)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (start) state_n = S_CALC;
         S_CALC:  if (cnt == '0) state_n = S_FIX;
         S_FIX:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         div_r <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         divz  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= (state == S_FIX);
         if (launch) begin
            cnt   <= CW'(WIDTH - 1);
            div_r <= div_op;
            neg_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn_op & a[WIDTH-1];
            divz  <= div_op & (b == '0);
         end else if (state == S_CALC) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (launch) begin
         acc  <= div_op ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
         opnd <= div_op ? b_abs : a_abs;
      end else if (state == S_CALC) begin
         acc <= acc_n;
      end
   end

   // HI/LO change only on FIX or on an idle-cycle MTHI/MTLO that is not pre-empted by start
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == S_FIX) begin
         if (div_r) begin
            lo <= q_fix;
            hi <= r_fix;
         end else begin
            {hi, lo} <= prod_fix;
         end
      end else if (state == S_IDLE && !start) begin
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random operations and hand-written corner sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   res_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      res_t               r;
      logic [63:0]        p;
      logic signed [63:0] sp;
      logic signed [31:0] sx, sy;
      sx = x;
      sy = y;
      case (o)
         2'b00: begin
            p = {32'b0, x} * {32'b0, y};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         2'b01: begin
            sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            r.hi = sp[63:32];
            r.lo = sp[31:0];
         end
         2'b10: begin
            if (y == 32'd0) begin
               r.lo = 32'hFFFFFFFF;
               r.hi = x;
            end else begin
               r.lo = x / y;
               r.hi = x % y;
            end
         end
         default: begin
            if (y == 32'd0) begin
               r.lo = 32'hFFFFFFFF;
               r.hi = x;
            end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               r.lo = 32'h80000000;
               r.hi = 32'd0;
            end else begin
               r.lo = sx / sy;
               r.hi = sx % sy;
            end
         end
      endcase
      return r;
   endfunction

   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input res_t e);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      if (push) sb_q.push_back(e);
      tick();
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   // n0 = number of edges already elapsed since (and including) the launch edge
   task automatic wait_done(input string name, input int n0);
      int   n;
      res_t e;
      n = n0;
      while (done !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done after %0d cycles expected done at 34", name, n);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
         chk({name, "_latency"}, 64'(n), 64'd34);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got done with empty queue expected a pending result", name);
         end else begin
            e = sb_q.pop_front();
            chk({name, "_hi"}, 64'(hi), 64'(e.hi));
            chk({name, "_lo"}, 64'(lo), 64'(e.lo));
         end
      end
   endtask

   vec_t tbl[10];
   res_t dummy;

   initial begin
      int          pulses;
      logic [31:0] hi_before, lo_before;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      dummy.hi = '0;
      dummy.lo = '0;
      tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[2] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
      tbl[3] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[5] = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      tbl[6] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
      tbl[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      tbl[8] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      tbl[9] = '{2'b00, 32'h12345678, 32'd0,        32'd0,        32'd0};

      reset = 1'b1;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      wdata = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);

      for (int i = 0; i < 10; i++) begin
         res_t e;
         e.hi = tbl[i].hi;
         e.lo = tbl[i].lo;
         launch(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, e);
         wait_done($sformatf("vec%0d", i), 1);
         tick();
         chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      end

      for (int i = 0; i < 6; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : $urandom;
         launch(ro, ra, rb, 1'b1, model(ro, ra, rb));
         wait_done($sformatf("rnd%0d", i), 1);
      end

      // start and MTHI while busy are both ignored; hi/lo hold during CALC
      hi_before = hi;
      lo_before = lo;
      launch(2'b00, 32'd3, 32'd4, 1'b1, model(2'b00, 32'd3, 32'd4));
      repeat (4) tick();
      op    = 2'b10;
      a     = 32'd9;
      b     = 32'd2;
      start = 1'b1;
      hi_we = 1'b1;
      wdata = 32'hAA;
      tick();
      start = 1'b0;
      hi_we = 1'b0;
      chk("busy_hi_hold", 64'(hi), 64'(hi_before));
      chk("busy_lo_hold", 64'(lo), 64'(lo_before));
      wait_done("ignored_start", 6);
      tick();
      chk("ignored_start_idle", 64'(busy), 64'd0);

      hi_we = 1'b1;
      wdata = 32'h1234;
      tick();
      hi_we = 1'b0;
      chk("mthi", 64'(hi), 64'h1234);

      // reset mid-operation aborts with no done pulse
      launch(2'b00, 32'd7, 32'd9, 1'b0, dummy);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) pulses++;
         tick();
      end
      chk("abort_no_done", 64'(pulses), 64'd0);

      // start accepted in the done cycle
      launch(2'b00, 32'd3, 32'd4, 1'b1, model(2'b00, 32'd3, 32'd4));
      wait_done("b2b_first", 1);
      launch(2'b10, 32'd9, 32'd2, 1'b1, '{32'd1, 32'd4});
      wait_done("b2b_second", 1);

      tick();
      lo_we = 1'b1;
      wdata = 32'h55;
      tick();
      lo_we = 1'b0;
      chk("mtlo", 64'(lo), 64'h55);
      chk("mtlo_hi_kept", 64'(hi), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
